// File: rtl/i2c_master_pkg.sv
// Shared types for the register-style I2C master: FSM states, SCL quarter
// phases and the latched transaction request.
package i2c_master_pkg;

  typedef enum logic [3:0] {
    IDLE, START, TX_BYTE, RX_ACK, RESTART, RX_BYTE, TX_NACK, STOP, DONE
  } I2cState;

  typedef enum logic [1:0] {Q0, Q1, Q2, Q3} Quarter;

  typedef struct packed {
    logic       rw;
    logic [6:0] dev_addr;
    logic [7:0] reg_addr;
    logic [7:0] wr_data;
  } I2cRequest;

endpackage

// File: rtl/i2c_quarter_timer.sv
// Divides clk into SCL quarter periods; freezes while a slave stretches SCL.
module i2c_quarter_timer
  import i2c_master_pkg::*;
#(
  parameter int CLK_DIV = 34
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   clear,
  input  logic   hold,
  output logic   tick,
  output Quarter quarter
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt;

  // tick marks the last cycle of the current quarter
  assign tick = (cnt == '0) && !hold && !clear;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt     <= CW'(CLK_DIV - 1);
      quarter <= Q0;
    end else if (tick) begin
      cnt     <= CW'(CLK_DIV - 1);
      quarter <= Quarter'(quarter + 2'd1);
    end else if (!hold) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/i2c_reg_master.sv
// Single-register I2C master: write (S,dev,reg,data,P) or read
// (S,dev,reg,Sr,dev|1,data,NACK,P) with a start/ready/done handshake.
module i2c_reg_master
  import i2c_master_pkg::*;
#(
  parameter int CLK_DIV = 34
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] dev_addr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wr_data,
  output logic       ready,
  output logic       done,
  output logic       ack_error,
  output logic [7:0] rd_data,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       scl_in,
  input  logic       sda_in
);

  I2cState   state, state_next;
  I2cRequest req;
  Quarter    quarter;
  logic      tick, phase_end, sample, hold, accept;
  logic [7:0] shreg;
  logic [2:0] bit_cnt;
  logic [1:0] byte_sel;  // 0: dev, 1: reg, 2: data or dev|1
  logic      ack_bit;
  logic      scl_d, sda_d, tx_bit;

  assign accept    = start && ready;
  assign hold      = !scl_oe && !scl_in;
  assign phase_end = tick && (quarter == Q3);
  assign sample    = tick && (quarter == Q2);

  i2c_quarter_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   ((state == IDLE) || (state == DONE)),
    .hold    (hold),
    .tick    (tick),
    .quarter (quarter)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    scl_d      = 1'b0;
    sda_d      = 1'b0;
    tx_bit     = (state == TX_BYTE) ? shreg[7] : 1'b1;
    unique case (state)
      IDLE:    if (accept) state_next = START;
      START,
      RESTART: if (phase_end) state_next = TX_BYTE;
      TX_BYTE: if (phase_end && bit_cnt == 3'd7) state_next = RX_ACK;
      RX_ACK: begin
        if (phase_end) begin
          if (ack_bit)               state_next = STOP;
          else if (byte_sel == 2'd0) state_next = TX_BYTE;
          else if (byte_sel == 2'd1) state_next = req.rw ? RESTART : TX_BYTE;
          else                       state_next = req.rw ? RX_BYTE : STOP;
        end
      end
      RX_BYTE: if (phase_end && bit_cnt == 3'd7) state_next = TX_NACK;
      TX_NACK: if (phase_end) state_next = STOP;
      STOP:    if (phase_end) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    unique case (state)
      START, RESTART: begin
        // a repeated start must first pull SCL low before raising SDA
        unique case (quarter)
          Q0: scl_d = (state == RESTART);
          Q1: scl_d = 1'b0;
          Q2: sda_d = 1'b1;
          Q3: begin scl_d = 1'b1; sda_d = 1'b1; end
        endcase
      end
      TX_BYTE, RX_ACK, RX_BYTE, TX_NACK: begin
        scl_d = (quarter == Q0) || (quarter == Q1);
        sda_d = ~tx_bit;
      end
      STOP: begin
        scl_d = (quarter == Q0) || (quarter == Q1);
        sda_d = (quarter != Q3);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ready     <= 1'b1;
      done      <= 1'b0;
      ack_error <= 1'b0;
      rd_data   <= '0;
      scl_oe    <= 1'b0;
      sda_oe    <= 1'b0;
      req       <= '0;
      shreg     <= '0;
      bit_cnt   <= '0;
      byte_sel  <= '0;
      ack_bit   <= 1'b0;
    end else begin
      scl_oe <= scl_d;
      sda_oe <= sda_d;
      done   <= (state == DONE);
      ready  <= (state == IDLE) && !accept;
      if (accept) begin
        req       <= '{rw: rw, dev_addr: dev_addr, reg_addr: reg_addr, wr_data: wr_data};
        ack_error <= 1'b0;
        shreg     <= {dev_addr, 1'b0};
        bit_cnt   <= '0;
        byte_sel  <= '0;
      end
      unique case (state)
        TX_BYTE: begin
          if (phase_end) begin
            shreg   <= {shreg[6:0], 1'b0};
            bit_cnt <= bit_cnt + 3'd1;
          end
        end
        RX_BYTE: begin
          if (sample)    shreg   <= {shreg[6:0], sda_in};
          if (phase_end) bit_cnt <= bit_cnt + 3'd1;
        end
        RX_ACK: begin
          if (sample) ack_bit <= sda_in;
          if (phase_end) begin
            if (ack_bit) begin
              ack_error <= 1'b1;
            end else if (byte_sel == 2'd0) begin
              shreg    <= req.reg_addr;
              byte_sel <= 2'd1;
            end else if (byte_sel == 2'd1 && !req.rw) begin
              shreg    <= req.wr_data;
              byte_sel <= 2'd2;
            end
          end
        end
        RESTART: begin
          if (phase_end) begin
            shreg    <= {req.dev_addr, 1'b1};
            byte_sel <= 2'd2;
          end
        end
        DONE: if (req.rw && !ack_error) rd_data <= shreg;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_reg_master.sv
// Directed and random transactions against a behavioural I2C slave that logs
// bus events; results compared with expectations computed from the protocol.
module tb_i2c_reg_master;

  localparam int CD   = 4;
  localparam int PH   = 4 * CD;
  localparam int EV_S = 'h100;
  localparam int EV_P = 'h200;
  localparam int EV_M = 'h300;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [6:0] dev_addr = '0;
  logic [7:0] reg_addr = '0;
  logic [7:0] wr_data = '0;
  logic       ready, done, ack_error, scl_oe, sda_oe, scl_in, sda_in;
  logic [7:0] rd_data;

  logic       stretch = 1'b0;
  logic       s_sda_low = 1'b0;
  int         ev_q[$];
  int         nack_idx = -1;
  int         stretch_idx = -1;
  logic [7:0] rd_val = '0;
  logic [7:0] exp_rd = '0;
  int         total = 0;
  int         bad = 0;

  assign scl_in = !(scl_oe || stretch);
  assign sda_in = !(sda_oe || s_sda_low);

  i2c_reg_master #(.CLK_DIV(CD)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .rw        (rw),
    .dev_addr  (dev_addr),
    .reg_addr  (reg_addr),
    .wr_data   (wr_data),
    .ready     (ready),
    .done      (done),
    .ack_error (ack_error),
    .rd_data   (rd_data),
    .scl_oe    (scl_oe),
    .sda_oe    (sda_oe),
    .scl_in    (scl_in),
    .sda_in    (sda_in)
  );

  initial forever #5 clk = ~clk;

  // Behavioural slave: logs S/P/bytes/master-ack, ACKs unless told otherwise,
  // returns rd_val on reads and can stretch one ACK slot by 50 cycles.
  initial begin : slave
    int bitpos, wbytes, scnt;
    logic [7:0] sh;
    logic is_addr, txm, go_tx, armed, prev_scl, prev_sda, prev_oe, s, d;
    bitpos = 0; wbytes = 0; scnt = 0; sh = '0;
    is_addr = 0; txm = 0; go_tx = 0; armed = 0;
    prev_scl = 1; prev_sda = 1; prev_oe = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        bitpos = 0; wbytes = 0; scnt = 0; is_addr = 0; txm = 0; go_tx = 0; armed = 0;
        stretch = 0; s_sda_low = 0;
        prev_scl = !scl_oe; prev_sda = !sda_oe; prev_oe = scl_oe;
      end else begin
        if (scnt > 0) begin
          scnt--;
          if (scnt == 0) stretch = 0;
        end else if (armed && prev_oe && !scl_oe) begin
          stretch = 1; scnt = 50; armed = 0;
        end
        prev_oe = scl_oe;
        s = !(scl_oe || stretch);
        d = !(sda_oe || s_sda_low);
        if (prev_scl && s && prev_sda && !d) begin
          ev_q.push_back(EV_S); bitpos = 0; is_addr = 1; txm = 0;
        end else if (prev_scl && s && !prev_sda && d) begin
          ev_q.push_back(EV_P); bitpos = 0; txm = 0; wbytes = 0; s_sda_low = 0;
        end else if (!prev_scl && s) begin
          if (bitpos < 8) begin
            sh = {sh[6:0], d}; bitpos++;
            if (bitpos == 8) ev_q.push_back(int'(sh));
          end else begin
            if (txm) ev_q.push_back(EV_M | int'(d));
            bitpos = 9;
          end
        end else if (prev_scl && !s) begin
          if (bitpos == 8) begin
            if (txm) s_sda_low = 0;
            else begin
              s_sda_low = (wbytes != nack_idx);
              if (wbytes == stretch_idx) armed = 1;
              if (is_addr && sh[0] && s_sda_low) go_tx = 1;
              wbytes++;
            end
            is_addr = 0;
          end else if (bitpos == 9) begin
            bitpos = 0; s_sda_low = 0;
            if (txm) txm = 0;
            else if (go_tx) begin txm = 1; go_tx = 0; s_sda_low = !rd_val[7]; end
          end else if (txm) begin
            s_sda_low = !rd_val[7 - bitpos];
          end
        end
        prev_scl = s;
        prev_sda = d;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_txn(input string tag, input logic t_rw, input logic [6:0] t_dev,
                        input logic [7:0] t_reg, input logic [7:0] t_dat, input logic [7:0] t_rdv,
                        input int t_nack, input int t_str, input bit busy_poke, input bit done_poke);
    int exp_ev[$];
    int nsent, phases, exp_lat, lat, got;
    logic exp_err;
    logic [7:0] w[3];
    w[0] = {t_dev, 1'b0};
    w[1] = t_reg;
    w[2] = t_rw ? {t_dev, 1'b1} : t_dat;
    exp_err = (t_nack >= 0) && (t_nack < 3);
    nsent = exp_err ? t_nack + 1 : 3;
    exp_ev.push_back(EV_S);
    for (int i = 0; i < nsent; i++) begin
      if (t_rw && i == 2) exp_ev.push_back(EV_S);
      exp_ev.push_back(int'(w[i]));
    end
    if (t_rw && !exp_err) begin
      exp_ev.push_back(int'(t_rdv));
      exp_ev.push_back(EV_M | 1);
    end
    exp_ev.push_back(EV_P);
    phases = 2 + 9 * nsent + ((t_rw && nsent == 3) ? 1 : 0) + ((t_rw && !exp_err) ? 9 : 0);
    exp_lat = phases * PH + 1 + ((t_str >= 0 && t_str < nsent) ? 50 : 0);
    if (t_rw && !exp_err) exp_rd = t_rdv;

    nack_idx = t_nack; stretch_idx = t_str; rd_val = t_rdv;
    ev_q.delete();
    rw = t_rw; dev_addr = t_dev; reg_addr = t_reg; wr_data = t_dat; start = 1;
    @(negedge clk);
    start = 0;
    chk({tag, ".ready_drop"}, 32'(ready), 0);
    lat = 0;
    while (!done && lat < 3000) begin
      if (busy_poke) begin
        start = (lat == 100);
        if (lat == 100) begin rw = ~t_rw; dev_addr = ~t_dev; reg_addr = ~t_reg; end
      end
      @(negedge clk);
      lat++;
    end
    start = 0;
    chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".ack_error"}, 32'(ack_error), 32'(exp_err));
    chk({tag, ".rd_data"}, 32'(rd_data), 32'(exp_rd));
    chk({tag, ".ev_count"}, 32'(ev_q.size()), 32'(exp_ev.size()));
    for (int i = 0; i < exp_ev.size(); i++) begin
      got = (i < ev_q.size()) ? ev_q[i] : -1;
      chk({tag, ".ev"}, 32'(got), 32'(exp_ev[i]));
    end
    if (done_poke) begin
      start = 1; rw = 0; dev_addr = 7'h55; reg_addr = 8'h00; wr_data = 8'hFF;
    end
    @(negedge clk);
    chk({tag, ".ready_after"}, 32'(ready), 1);
    chk({tag, ".done_pulse"}, 32'(done), 0);
    start = 0;
  endtask

  initial begin : main
    int lat;
    repeat (3) @(negedge clk);
    chk("rst.scl_oe", 32'(scl_oe), 0);
    chk("rst.sda_oe", 32'(sda_oe), 0);
    chk("rst.ready", 32'(ready), 1);
    chk("rst.done", 32'(done), 0);
    chk("rst.ack_error", 32'(ack_error), 0);
    chk("rst.rd_data", 32'(rd_data), 0);
    reset = 0;
    @(negedge clk);

    do_txn("wr_ack", 1'b0, 7'h39, 8'h41, 8'h10, 8'h00, -1, -1, 0, 0);
    do_txn("rd_ack", 1'b1, 7'h39, 8'h42, 8'h00, 8'hA5, -1, -1, 0, 0);
    do_txn("addr_nack", 1'b1, 7'h39, 8'h43, 8'h00, 8'h5A, 0, -1, 0, 0);
    do_txn("stretch", 1'b0, 7'h39, 8'h41, 8'h10, 8'h00, -1, 1, 0, 0);
    do_txn("pokes", 1'b0, 7'h22, 8'h07, 8'hC3, 8'h00, -1, -1, 1, 1);
    do_txn("first_ready", 1'b1, 7'h11, 8'h80, 8'h00, 8'h3C, -1, -1, 0, 0);

    // reset during bit 3 of the data byte of a write
    ev_q.delete(); nack_idx = -1; stretch_idx = -1;
    rw = 0; dev_addr = 7'h39; reg_addr = 8'h41; wr_data = 8'h10; start = 1;
    @(negedge clk);
    start = 0;
    lat = 0;
    while (lat < 22 * PH + 5) begin @(negedge clk); lat++; end
    reset = 1;
    @(negedge clk);
    chk("midrst.scl_oe", 32'(scl_oe), 0);
    chk("midrst.sda_oe", 32'(sda_oe), 0);
    chk("midrst.ready", 32'(ready), 1);
    chk("midrst.done", 32'(done), 0);
    @(negedge clk);
    reset = 0;
    exp_rd = '0;
    do_txn("after_rst", 1'b0, 7'h39, 8'h41, 8'h10, 8'h00, -1, -1, 0, 0);

    for (int k = 0; k < 8; k++) begin
      int nk;
      nk = int'($urandom_range(0, 6));
      do_txn("rand", 1'($urandom_range(0, 1)), 7'($urandom), 8'($urandom), 8'($urandom),
             8'($urandom), (nk < 3) ? nk : -1, -1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
